// File: rtl/clk_health_sel_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : clk_health_sel_ctrl
// Brief    : Frequency supervisor for CLK_NUM clock sources plus select and
//            automatic fail-over controller for a glitch-free clock switch.
// Revision : 1.0  initial release
// =============================================================================
module clk_health_sel_ctrl #(
    parameter int CLK_NUM  = 4,
    parameter int WIN_CYC  = 256,
    parameter int MIN_CNT  = 200,
    parameter int MAX_CNT  = 312,
    parameter int FAIL_WIN = 2,
    parameter int OK_WIN   = 4,
    parameter int HOLD_CYC = 16,
    parameter int DEF_SEL  = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CLK_NUM-1:0]         clk_tgl,
    input  logic                       auto_en,
    input  logic                       sw_sel_vld,
    input  logic [$clog2(CLK_NUM)-1:0] sw_sel,
    output logic                       sw_rej,
    output logic [CLK_NUM-1:0]         clk_fail,
    output logic [$clog2(CLK_NUM)-1:0] sel,
    output logic                       sel_chg,
    output logic                       all_fail
);

    localparam int SEL_W  = $clog2(CLK_NUM);
    localparam int WIN_W  = $clog2(WIN_CYC);
    localparam int CNT_W  = $clog2(MAX_CNT + 2);
    localparam int BAD_W  = $clog2(FAIL_WIN + 1);
    localparam int GOOD_W = $clog2(OK_WIN + 1);
    localparam int HOLD_W = $clog2(HOLD_CYC + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Toggle synchronizers; every transition of the synced toggle is one source cycle
    logic [CLK_NUM-1:0] r_sync1;
    logic [CLK_NUM-1:0] r_sync2;
    logic [CLK_NUM-1:0] r_hist;
    logic [CLK_NUM-1:0] w_edge;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
        end else begin
            r_sync1 <= clk_tgl;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
        end
    end

    assign w_edge = r_sync2 ^ r_hist;

    logic [WIN_W-1:0] r_win_cnt;
    logic             w_term;

    assign w_term = (r_win_cnt == WIN_W'(WIN_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win_cnt <= '0;
        end else begin
            r_win_cnt <= w_term ? '0 : r_win_cnt + 1'b1;
        end
    end

    logic [CLK_NUM-1:0] w_fail_nxt;

    for (genvar gi = 0; gi < CLK_NUM; gi++) begin : g_src
        logic [CNT_W-1:0]  r_cnt;
        logic [CNT_W-1:0]  w_cnt_tot;
        logic [BAD_W-1:0]  r_bad_run;
        logic [BAD_W-1:0]  w_bad_nxt;
        logic [GOOD_W-1:0] r_good_run;
        logic [GOOD_W-1:0] w_good_nxt;
        logic              w_good;
        logic              w_fail;

        // The terminal-cycle edge is folded into the closing window's total
        always_comb begin
            w_cnt_tot = r_cnt;
            if (w_edge[gi] && (r_cnt != '1)) begin
                w_cnt_tot = r_cnt + 1'b1;
            end
            w_good = (w_cnt_tot != '0) &&
                     (w_cnt_tot >= CNT_W'(MIN_CNT)) &&
                     (w_cnt_tot <= CNT_W'(MAX_CNT));
            w_bad_nxt  = r_bad_run;
            w_good_nxt = r_good_run;
            w_fail     = clk_fail[gi];
            if (w_term) begin
                if (w_good) begin
                    w_bad_nxt = '0;
                    if (r_good_run != GOOD_W'(OK_WIN)) begin
                        w_good_nxt = r_good_run + 1'b1;
                    end
                end else begin
                    w_good_nxt = '0;
                    if (r_bad_run != BAD_W'(FAIL_WIN)) begin
                        w_bad_nxt = r_bad_run + 1'b1;
                    end
                end
                if (w_bad_nxt == BAD_W'(FAIL_WIN)) begin
                    w_fail = 1'b1;
                end else if (w_good_nxt == GOOD_W'(OK_WIN)) begin
                    w_fail = 1'b0;
                end
            end
        end

        assign w_fail_nxt[gi] = w_fail;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_cnt      <= '0;
                r_bad_run  <= '0;
                r_good_run <= '0;
            end else begin
                r_cnt      <= w_term ? '0 : w_cnt_tot;
                r_bad_run  <= w_bad_nxt;
                r_good_run <= w_good_nxt;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_fail <= '0;
        end else begin
            clk_fail <= w_fail_nxt;
        end
    end

    // Downward scan so the lowest healthy non-selected index ends up as target
    logic             w_sel_fail;
    logic             w_sw_ok;
    logic             w_tgt_vld;
    logic [SEL_W-1:0] w_tgt;

    always_comb begin
        w_sel_fail = 1'b0;
        w_sw_ok    = 1'b0;
        w_tgt_vld  = 1'b0;
        w_tgt      = '0;
        for (int i = CLK_NUM - 1; i >= 0; i--) begin
            if (SEL_W'(i) == sel) begin
                w_sel_fail = clk_fail[i];
            end else if (!clk_fail[i]) begin
                w_tgt_vld = 1'b1;
                w_tgt     = SEL_W'(i);
            end
            if (SEL_W'(i) == sw_sel) begin
                w_sw_ok = !clk_fail[i];
            end
        end
    end

    state_t            r_state;
    logic [HOLD_W-1:0] r_hold_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            sel        <= SEL_W'(DEF_SEL);
            sel_chg    <= 1'b0;
            sw_rej     <= 1'b0;
            all_fail   <= 1'b0;
        end else begin
            sel_chg <= 1'b0;
            sw_rej  <= 1'b0;
            // A healthy non-selected source means a fail-over target exists again
            if (w_tgt_vld) begin
                all_fail <= 1'b0;
            end else if (&clk_fail) begin
                all_fail <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (auto_en && w_sel_fail) begin
                        sw_rej <= sw_sel_vld;
                        if (w_tgt_vld) begin
                            sel        <= w_tgt;
                            sel_chg    <= 1'b1;
                            r_hold_cnt <= '0;
                            r_state    <= ST_HOLD;
                        end else begin
                            all_fail <= 1'b1;
                        end
                    end else if (sw_sel_vld) begin
                        if (!w_sw_ok) begin
                            sw_rej <= 1'b1;
                        end else if (sw_sel != sel) begin
                            sel        <= sw_sel;
                            sel_chg    <= 1'b1;
                            r_hold_cnt <= '0;
                            r_state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    sw_rej <= sw_sel_vld;
                    if (r_hold_cnt == HOLD_W'(HOLD_CYC - 1)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_health_sel_ctrl.sv
`default_nettype none
// =============================================================================
// Module   : tb_clk_health_sel_ctrl
// Brief    : Directed self-checking bench for clk_health_sel_ctrl.
// Revision : 1.0  initial release
// =============================================================================
module tb_clk_health_sel_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] clk_tgl = 4'b0000;
    logic       auto_en = 1'b0;
    logic       sw_sel_vld = 1'b0;
    logic [1:0] sw_sel = 2'd0;
    logic       sw_rej;
    logic [3:0] clk_fail;
    logic [1:0] sel;
    logic       sel_chg;
    logic       all_fail;

    int checks = 0;
    int errors = 0;

    // Per-source drive mode: 0 stopped, 1 nominal (edge every 2 cycles), 2 double rate
    int mode [4] = '{1, 1, 1, 1};
    bit phase = 1'b0;

    clk_health_sel_ctrl #(
        .CLK_NUM (4),
        .WIN_CYC (256),
        .MIN_CNT (100),
        .MAX_CNT (156),
        .FAIL_WIN(2),
        .OK_WIN  (4),
        .HOLD_CYC(16),
        .DEF_SEL (0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clk_tgl   (clk_tgl),
        .auto_en   (auto_en),
        .sw_sel_vld(sw_sel_vld),
        .sw_sel    (sw_sel),
        .sw_rej    (sw_rej),
        .clk_fail  (clk_fail),
        .sel       (sel),
        .sel_chg   (sel_chg),
        .all_fail  (all_fail)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        phase = ~phase;
        for (int i = 0; i < 4; i++) begin
            if (mode[i] == 2 || (mode[i] == 1 && phase)) begin
                clk_tgl[i] = ~clk_tgl[i];
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached (checks=%0d errors=%0d)", checks, errors);
        $fatal(1);
    end

    task automatic do_reset();
        rst        = 1'b1;
        auto_en    = 1'b0;
        sw_sel_vld = 1'b0;
        sw_sel     = 2'd0;
        for (int i = 0; i < 4; i++) mode[i] = 1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_fail_bit(input int idx, input logic val, input int budget, output int n);
        n = 0;
        while (n < budget && clk_fail[idx] !== val) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic sw_req(input logic [1:0] idx);
        sw_sel_vld = 1'b1;
        sw_sel     = idx;
        @(negedge clk);
        sw_sel_vld = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({clk_fail, sel, sel_chg, sw_rej, all_fail} !== 9'b0) begin
            errors++;
            $display("FAIL reset_outputs: got fail=%b sel=%0d chg=%b rej=%b all=%b, want all zero",
                     clk_fail, sel, sel_chg, sw_rej, all_fail);
        end
        do_reset();
        @(negedge clk);
        checks++;
        if ({clk_fail, sel, all_fail} !== 7'b0) begin
            errors++;
            $display("FAIL reset_release: got fail=%b sel=%0d all=%b, want 0/0/0", clk_fail, sel, all_fail);
        end
    endtask

    task automatic test_nominal();
        do_reset();
        auto_en = 1'b1;
        checks++;
        for (int c = 0; c < 1100; c++) begin
            @(negedge clk);
            if ({clk_fail, sel, sel_chg, sw_rej, all_fail} !== 9'b0) begin
                errors++;
                $display("FAIL nominal_quiet: cycle %0d got fail=%b sel=%0d chg=%b rej=%b all=%b, want all zero",
                         c, clk_fail, sel, sel_chg, sw_rej, all_fail);
                break;
            end
        end
    endtask

    task automatic test_failover();
        int n;
        do_reset();
        auto_en = 1'b1;
        repeat (10) @(negedge clk);
        mode[0] = 0;
        wait_fail_bit(0, 1'b1, 772, n);
        checks++;
        if (clk_fail !== 4'b0001 || sel !== 2'd0) begin
            errors++;
            $display("FAIL failover_detect: after %0d cyc got fail=%b sel=%0d, want 0001 sel 0", n, clk_fail, sel);
        end
        @(negedge clk);
        checks++;
        if (sel !== 2'd1 || sel_chg !== 1'b1) begin
            errors++;
            $display("FAIL failover_switch: got sel=%0d chg=%b, want sel 1 chg 1", sel, sel_chg);
        end
        @(negedge clk);
        checks++;
        if (sel_chg !== 1'b0 || sel !== 2'd1) begin
            errors++;
            $display("FAIL failover_pulse: got sel=%0d chg=%b, want sel 1 chg 0", sel, sel_chg);
        end
    endtask

    task automatic test_multi_fail();
        int n;
        do_reset();
        auto_en = 1'b1;
        repeat (10) @(negedge clk);
        mode[0] = 0;
        mode[1] = 0;
        wait_fail_bit(0, 1'b1, 800, n);
        checks++;
        if (clk_fail !== 4'b0011) begin
            errors++;
            $display("FAIL multi_detect: got fail=%b, want 0011", clk_fail);
        end
        @(negedge clk);
        checks++;
        if (sel !== 2'd2 || sel_chg !== 1'b1) begin
            errors++;
            $display("FAIL multi_target: got sel=%0d chg=%b, want sel 2 chg 1", sel, sel_chg);
        end
        repeat (20) @(negedge clk);
        mode[2] = 0;
        mode[3] = 0;
        wait_fail_bit(2, 1'b1, 800, n);
        checks++;
        if (clk_fail !== 4'b1111) begin
            errors++;
            $display("FAIL all_detect: got fail=%b, want 1111", clk_fail);
        end
        @(negedge clk);
        checks++;
        if (all_fail !== 1'b1 || sel !== 2'd2 || sel_chg !== 1'b0) begin
            errors++;
            $display("FAIL all_fail_set: got all=%b sel=%0d chg=%b, want all 1 sel 2 chg 0", all_fail, sel, sel_chg);
        end
        mode[3] = 1;
        wait_fail_bit(3, 1'b0, 1300, n);
        checks++;
        if (clk_fail !== 4'b0111 || all_fail !== 1'b1) begin
            errors++;
            $display("FAIL recover_detect: got fail=%b all=%b, want 0111 all 1", clk_fail, all_fail);
        end
        @(negedge clk);
        checks++;
        if (all_fail !== 1'b0 || sel !== 2'd3 || sel_chg !== 1'b1) begin
            errors++;
            $display("FAIL recover_switch: got all=%b sel=%0d chg=%b, want all 0 sel 3 chg 1", all_fail, sel, sel_chg);
        end
    endtask

    task automatic test_sw_select();
        int n;
        do_reset();
        repeat (5) @(negedge clk);
        sw_req(2'd2);
        checks++;
        if (sel !== 2'd2 || sel_chg !== 1'b1 || sw_rej !== 1'b0) begin
            errors++;
            $display("FAIL sw_accept: got sel=%0d chg=%b rej=%b, want 2/1/0", sel, sel_chg, sw_rej);
        end
        repeat (2) @(negedge clk);
        sw_req(2'd1);
        checks++;
        if (sw_rej !== 1'b1 || sel !== 2'd2) begin
            errors++;
            $display("FAIL sw_hold_reject: got rej=%b sel=%0d, want rej 1 sel 2", sw_rej, sel);
        end
        repeat (20) @(negedge clk);
        sw_req(2'd2);
        checks++;
        if (sw_rej !== 1'b0 || sel_chg !== 1'b0 || sel !== 2'd2) begin
            errors++;
            $display("FAIL sw_same_noop: got rej=%b chg=%b sel=%0d, want 0/0/2", sw_rej, sel_chg, sel);
        end
        mode[3] = 0;
        wait_fail_bit(3, 1'b1, 800, n);
        sw_req(2'd3);
        checks++;
        if (sw_rej !== 1'b1 || sel !== 2'd2 || clk_fail !== 4'b1000) begin
            errors++;
            $display("FAIL sw_failed_reject: got rej=%b sel=%0d fail=%b, want rej 1 sel 2 fail 1000",
                     sw_rej, sel, clk_fail);
        end
        @(negedge clk);
        sw_req(2'd1);
        checks++;
        if (sel !== 2'd1 || sel_chg !== 1'b1 || sw_rej !== 1'b0) begin
            errors++;
            $display("FAIL sw_accept_after_hold: got sel=%0d chg=%b rej=%b, want 1/1/0", sel, sel_chg, sw_rej);
        end
    endtask

    task automatic test_overfreq();
        int n;
        do_reset();
        mode[1] = 2;
        wait_fail_bit(1, 1'b1, 800, n);
        checks++;
        if (clk_fail !== 4'b0010 || sel !== 2'd0) begin
            errors++;
            $display("FAIL overfreq_detect: got fail=%b sel=%0d, want 0010 sel 0", clk_fail, sel);
        end
        mode[1] = 1;
        repeat (1023) @(negedge clk);
        checks++;
        if (clk_fail[1] !== 1'b1) begin
            errors++;
            $display("FAIL overfreq_early_clear: got fail1=%b one cycle before 4 windows, want 1", clk_fail[1]);
        end
        @(negedge clk);
        checks++;
        if (clk_fail !== 4'b0000) begin
            errors++;
            $display("FAIL overfreq_clear: got fail=%b after 4 good windows, want 0000", clk_fail);
        end
    endtask

    task automatic test_rst_hold();
        int n;
        do_reset();
        auto_en = 1'b1;
        repeat (10) @(negedge clk);
        mode[0] = 0;
        mode[1] = 0;
        wait_fail_bit(0, 1'b1, 800, n);
        @(negedge clk);
        checks++;
        if (clk_fail !== 4'b0011 || sel !== 2'd2) begin
            errors++;
            $display("FAIL rst_setup: got fail=%b sel=%0d, want 0011 sel 2", clk_fail, sel);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({clk_fail, sel, sel_chg, sw_rej, all_fail} !== 9'b0) begin
            errors++;
            $display("FAIL rst_async: got fail=%b sel=%0d chg=%b rej=%b all=%b, want all zero",
                     clk_fail, sel, sel_chg, sw_rej, all_fail);
        end
        @(negedge clk);
        rst        = 1'b0;
        sw_sel_vld = 1'b1;
        sw_sel     = 2'd3;
        @(negedge clk);
        sw_sel_vld = 1'b0;
        checks++;
        if (sel !== 2'd3 || sel_chg !== 1'b1 || sw_rej !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold_lost: got sel=%0d chg=%b rej=%b, want 3/1/0", sel, sel_chg, sw_rej);
        end
        checks++;
        for (int k = 2; k <= 511; k++) begin
            @(negedge clk);
            if (clk_fail !== 4'b0000) begin
                errors++;
                $display("FAIL rst_window_early: cycle %0d got fail=%b, want 0000", k, clk_fail);
                break;
            end
        end
        @(negedge clk);
        checks++;
        if (clk_fail !== 4'b0011 || sel !== 2'd3) begin
            errors++;
            $display("FAIL rst_window_restart: got fail=%b sel=%0d at cycle 512, want 0011 sel 3", clk_fail, sel);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_failover();
        test_multi_fail();
        test_sw_select();
        test_overfreq();
        test_rst_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
